// File: rtl/key_event_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_ctrl_if
//  Description : Bundle of the key-event controller signals. The scanner,
//                control-register and pop/clear inputs go into the block, and
//                the event FIFO status and head go out of it.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_event_ctrl_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          key_it;
  logic [3:0]    key_val;
  logic          key_held;
  logic          irq_en;
  logic          evt_pop;
  logic          ovf_clr;
  logic [5:0]    evt_data;
  logic          evt_valid;
  logic [CW-1:0] evt_count;
  logic          ovf;
  logic          irq;

  // Driver side: scanner, register slave and firmware strobes.
  modport master (
    output key_it, key_val, key_held, irq_en, evt_pop, ovf_clr,
    input  evt_data, evt_valid, evt_count, ovf, irq
  );

  // Controller side.
  modport slave (
    input  key_it, key_val, key_held, irq_en, evt_pop, ovf_clr,
    output evt_data, evt_valid, evt_count, ovf, irq
  );
endinterface
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_ctrl
//  Description : Turns keypad scanner presses into PRESS/LONG/REPEAT/RELEASE
//                events and queues them in a show-ahead FIFO for firmware.
//                Drives the keypad interrupt while events are pending.
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_ctrl #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic           HCLK,
  input  logic           HRESET,
  key_event_ctrl_if.slave bus
);

  localparam int C_AW  = $clog2(FIFO_DEPTH);
  localparam int C_CW  = C_AW + 1;
  localparam int C_PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int C_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int C_HW  = $clog2(C_MAX + 1);

  localparam logic [C_PW-1:0] C_TICK_LAST = C_PW'(TICK_DIV - 1);
  localparam logic [C_HW-1:0] C_LONG_LAST = C_HW'(LONG_TICKS - 1);
  localparam logic [C_HW-1:0] C_REP_LAST  = C_HW'(REPEAT_TICKS - 1);
  localparam logic [C_CW-1:0] C_DEPTH     = C_CW'(FIFO_DEPTH);

  localparam logic [1:0] C_EVT_PRESS   = 2'b00;
  localparam logic [1:0] C_EVT_LONG    = 2'b01;
  localparam logic [1:0] C_EVT_REPEAT  = 2'b10;
  localparam logic [1:0] C_EVT_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CAPTURE   = 2'd1,
    S_PRESSED   = 2'd2,
    S_REPEATING = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_code;
  logic [C_HW-1:0] r_hold;
  logic [C_PW-1:0] r_presc;
  logic            w_tick;

  logic            w_push;
  logic [5:0]      w_push_data;

  logic [5:0]      r_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wr;
  logic [C_AW-1:0] r_rd;
  logic [C_CW-1:0] r_count;
  logic [5:0]      r_evt_data;
  logic            r_evt_valid;
  logic            r_ovf;
  logic            r_irq;

  logic            w_do_pop;
  logic            w_do_push;
  logic            w_drop;
  logic [C_CW-1:0] w_count_next;
  logic [C_CW-1:0] w_remain;
  logic [C_AW-1:0] w_rd_next;
  logic [5:0]      w_head_next;

  assign w_tick = (r_presc == C_TICK_LAST);

  // Free-running hold-timer prescaler; wraps and pulses tick every TICK_DIV cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET || w_tick) r_presc <= '0;
    else                  r_presc <= r_presc + C_PW'(1);
  end

  // Decide which event, if any, the key sequencer produces this cycle.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 6'd0;
    case (r_state)
      S_CAPTURE: begin
        w_push      = 1'b1;
        w_push_data = {C_EVT_PRESS, bus.key_val};
      end
      S_PRESSED: begin
        if (!bus.key_held) begin
          w_push      = 1'b1;
          w_push_data = {C_EVT_RELEASE, r_code};
        end else if (w_tick && (r_hold == C_LONG_LAST)) begin
          w_push      = 1'b1;
          w_push_data = {C_EVT_LONG, r_code};
        end
      end
      S_REPEATING: begin
        if (!bus.key_held) begin
          w_push      = 1'b1;
          w_push_data = {C_EVT_RELEASE, r_code};
        end else if (w_tick && (r_hold == C_REP_LAST)) begin
          w_push      = 1'b1;
          w_push_data = {C_EVT_REPEAT, r_code};
        end
      end
      default: ;
    endcase
  end

  // Key sequencer: capture the code, time the hold, return to idle on release.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_code  <= 4'd0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.key_it) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_code  <= bus.key_val;
          r_hold  <= '0;
          r_state <= S_PRESSED;
        end
        S_PRESSED: begin
          if (!bus.key_held) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_hold == C_LONG_LAST) begin
              r_hold  <= '0;
              r_state <= S_REPEATING;
            end else begin
              r_hold <= r_hold + C_HW'(1);
            end
          end
        end
        S_REPEATING: begin
          if (!bus.key_held) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_hold == C_REP_LAST) r_hold <= '0;
            else                      r_hold <= r_hold + C_HW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    w_do_pop     = bus.evt_pop && (r_count != '0);
    w_do_push    = w_push && ((r_count != C_DEPTH) || w_do_pop);
    w_drop       = w_push && (r_count == C_DEPTH) && !w_do_pop;
    w_count_next = r_count + C_CW'(w_do_push) - C_CW'(w_do_pop);
    w_remain     = r_count - C_CW'(w_do_pop);
    w_rd_next    = r_rd + C_AW'(w_do_pop);
    w_head_next  = r_evt_data;
    if (w_count_next != '0) begin
      // When nothing older survives the pop, the new push becomes the head.
      if (w_remain == '0) w_head_next = w_push_data;
      else                w_head_next = r_mem[w_rd_next];
    end
  end

  // Event storage; contents are only read once written, so no reset is needed.
  always_ff @(posedge HCLK) begin
    if (w_do_push) r_mem[r_wr] <= w_push_data;
  end

  // FIFO pointers, registered show-ahead head, status flags and interrupt.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_evt_data  <= 6'd0;
      r_evt_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + C_AW'(1);
      r_rd        <= w_rd_next;
      r_count     <= w_count_next;
      r_evt_data  <= w_head_next;
      r_evt_valid <= (w_count_next != '0);
      r_irq       <= bus.irq_en && r_evt_valid;
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.evt_data  = r_evt_data;
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_count = r_count;
  assign bus.ovf       = r_ovf;
  assign bus.irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_ctrl
//  Description : Self-checking bench for key_event_ctrl with directed
//                scenarios and randomized traffic against an event-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_event_ctrl;
  localparam int FIFO_DEPTH   = 4;
  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 5;
  localparam int REPEAT_TICKS = 3;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  key_event_ctrl_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  key_event_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH), .TICK_DIV(TICK_DIV),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus)
  );

  // Reference model: key phase, ticks since press, queue-based FIFO.
  int         m_phase;      // 0 no key, 1 press just reported, 2 key down
  int         m_ticks;
  int         m_cyc;
  logic [3:0] m_code;
  logic [5:0] m_q[$];
  logic [5:0] m_log[$];
  logic [5:0] m_data;
  logic [5:0] m_pd;
  logic [5:0] m_tmp;
  logic       m_ovf, m_irq, m_have, m_tick, m_vbefore, m_popped, m_full;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_cyc = 0; m_code = 4'd0;
      m_q.delete(); m_log.delete();
      m_data = 6'd0; m_ovf = 1'b0; m_irq = 1'b0;
    end else begin
      m_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_have = 1'b0;
      m_pd   = 6'd0;
      if (m_phase == 0) begin
        if (bus.key_it) m_phase = 1;
      end else if (m_phase == 1) begin
        m_code = bus.key_val; m_have = 1'b1; m_pd = {2'b00, m_code};
        m_ticks = 0; m_phase = 2;
      end else begin
        if (!bus.key_held) begin
          m_have = 1'b1; m_pd = {2'b11, m_code}; m_phase = 0;
        end else if (m_tick) begin
          m_ticks++;
          if (m_ticks == LONG_TICKS) begin
            m_have = 1'b1; m_pd = {2'b01, m_code};
          end else if (m_ticks > LONG_TICKS && ((m_ticks - LONG_TICKS) % REPEAT_TICKS) == 0) begin
            m_have = 1'b1; m_pd = {2'b10, m_code};
          end
        end
      end
      m_vbefore = (m_q.size() > 0);
      m_popped  = bus.evt_pop && (m_q.size() > 0);
      m_full    = (m_q.size() == FIFO_DEPTH);
      if (m_popped) m_tmp = m_q.pop_front();
      if (m_have) begin
        if (!m_full || m_popped) begin
          m_q.push_back(m_pd); m_log.push_back(m_pd);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (!(m_have && m_full && !m_popped) && bus.ovf_clr) m_ovf = 1'b0;
      m_irq = bus.irq_en && m_vbefore;
      if (m_q.size() > 0) m_data = m_q[0];
      m_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.key_it = 0; bus.key_held = 0; bus.key_val = 0;
    bus.evt_pop = 0; bus.ovf_clr = 0; bus.irq_en = 0;
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic press(input logic [3:0] code, input int held);
    bus.key_val = code; bus.key_it = 1; bus.key_held = 1;
    step();
    bus.key_it = 0;
    repeat (held - 1) step();
    bus.key_held = 0;
    step(); step(); step();
  endtask

  task automatic test_reset();
    bus.irq_en = 1;
    press(4'h9, 4);
    do_reset();
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.evt_valid); end
    checks++; if (bus.evt_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.evt_count); end
    checks++; if (bus.evt_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.evt_data); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_short_press();
    do_reset();
    bus.irq_en = 1;
    bus.key_val = 4'h9; bus.key_it = 1; bus.key_held = 1;
    step();
    bus.key_it = 0;
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL press_latency1: valid got %b expected 0", bus.evt_valid); end
    step();
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_data !== 6'h09) begin errors++; $display("FAIL press_latency2: valid %b data %h expected 1 09", bus.evt_valid, bus.evt_data); end
    repeat (8) step();
    bus.key_held = 0;
    step(); step();
    checks++; if (bus.evt_count !== CW'(2)) begin errors++; $display("FAIL short_count: got %0d expected 2", bus.evt_count); end
    checks++; if (bus.evt_data !== 6'h09) begin errors++; $display("FAIL short_head: got %h expected 09", bus.evt_data); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL short_irq: got %b expected 1", bus.irq); end
    bus.evt_pop = 1; step(); bus.evt_pop = 0;
    checks++; if (bus.evt_data !== 6'h39 || bus.evt_count !== CW'(1)) begin errors++; $display("FAIL short_release: data %h count %0d expected 39 1", bus.evt_data, bus.evt_count); end
    bus.evt_pop = 1; step(); bus.evt_pop = 0;
    checks++; if (bus.evt_valid !== 1'b0 || bus.evt_data !== 6'h39) begin errors++; $display("FAIL empty_hold: valid %b data %h expected 0 39", bus.evt_valid, bus.evt_data); end
    step();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", bus.irq); end
  endtask

  task automatic test_long_hold();
    logic [5:0] got[$];
    int reps;
    do_reset();
    bus.irq_en = 1;
    bus.key_val = 4'h3; bus.key_it = 1; bus.key_held = 1;
    step();
    bus.key_it = 0;
    for (int i = 0; i < 68; i++) begin
      if (i == 60) bus.key_held = 0;
      if (bus.evt_valid) begin got.push_back(bus.evt_data); bus.evt_pop = 1; end
      else bus.evt_pop = 0;
      step();
    end
    bus.evt_pop = 0;
    checks++; if (got.size() !== m_log.size()) begin errors++; $display("FAIL long_len: got %0d expected %0d", got.size(), m_log.size()); end
    for (int i = 0; i < got.size() && i < m_log.size(); i++) begin
      checks++; if (got[i] !== m_log[i]) begin errors++; $display("FAIL long_evt%0d: got %h expected %h", i, got[i], m_log[i]); end
    end
    reps = 0;
    foreach (got[i]) if (got[i][5:4] == 2'b10) reps++;
    checks++; if (got.size() < 4 || got[0] !== 6'h03 || got[1] !== 6'h13 || got[got.size()-1] !== 6'h33 || reps < 2 || reps > 4) begin
      errors++; $display("FAIL long_shape: got %0d events with %0d repeats, expected PRESS,LONG,2-4 REPEAT,RELEASE", got.size(), reps);
    end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL long_ovf: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp[4];
    exp[0] = 6'h01; exp[1] = 6'h31; exp[2] = 6'h02; exp[3] = 6'h32;
    do_reset();
    press(4'h1, 3); press(4'h2, 3); press(4'h5, 3);
    checks++; if (bus.evt_count !== CW'(4) || bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: count %0d ovf %b expected 4 1", bus.evt_count, bus.ovf); end
    checks++; if (bus.evt_data !== 6'h01) begin errors++; $display("FAIL ovf_head: got %h expected 01", bus.evt_data); end
    bus.ovf_clr = 1; step(); bus.ovf_clr = 0;
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", bus.ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.evt_data !== exp[i]) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, bus.evt_data, exp[i]); end
      bus.evt_pop = 1; step(); bus.evt_pop = 0;
    end
  endtask

  task automatic test_full_push_pop();
    logic [5:0] exp[4];
    exp[0] = 6'h07; exp[1] = 6'h37; exp[2] = 6'h0A; exp[3] = 6'h3A;
    do_reset();
    press(4'h6, 3); press(4'h7, 3);
    bus.evt_pop = 1; step(); bus.evt_pop = 0;
    bus.key_val = 4'hA; bus.key_it = 1; bus.key_held = 1;
    step(); bus.key_it = 0; step(); step();
    checks++; if (bus.evt_count !== CW'(4)) begin errors++; $display("FAIL full_pre: count %0d expected 4", bus.evt_count); end
    bus.key_held = 0; bus.evt_pop = 1;
    step();
    bus.evt_pop = 0;
    checks++; if (bus.evt_count !== CW'(4) || bus.ovf !== 1'b0) begin errors++; $display("FAIL full_pushpop: count %0d ovf %b expected 4 0", bus.evt_count, bus.ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.evt_data !== exp[i]) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, bus.evt_data, exp[i]); end
      bus.evt_pop = 1; step(); bus.evt_pop = 0;
    end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.evt_pop = 1; step(); bus.evt_pop = 0;
    checks++; if (bus.evt_count !== '0 || bus.evt_valid !== 1'b0 || bus.evt_data !== 6'd0) begin errors++; $display("FAIL pop_empty: count %0d valid %b data %h expected 0 0 00", bus.evt_count, bus.evt_valid, bus.evt_data); end
    bus.key_val = 4'hB; bus.key_it = 1; bus.key_held = 1;
    step(); bus.key_it = 0; step(); step();
    bus.key_val = 4'h2; bus.key_it = 1;
    step(); bus.key_it = 0; step(); step();
    bus.key_held = 0;
    step(); step();
    checks++; if (bus.evt_count !== CW'(2) || bus.evt_data !== 6'h0B) begin errors++; $display("FAIL spurious_it: count %0d head %h expected 2 0b", bus.evt_count, bus.evt_data); end
    bus.evt_pop = 1; step(); bus.evt_pop = 0;
    checks++; if (bus.evt_data !== 6'h3B) begin errors++; $display("FAIL spurious_code: got %h expected 3b", bus.evt_data); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus.irq_en = 1;
    bus.key_val = 4'hC; bus.key_it = 1; bus.key_held = 1;
    step(); bus.key_it = 0;
    repeat (30) step();
    checks++; if (bus.evt_count < CW'(2) || bus.irq !== 1'b1) begin errors++; $display("FAIL midhold_pre: count %0d irq %b expected >=2 1", bus.evt_count, bus.irq); end
    rst = 1; step(); rst = 0;
    checks++; if (bus.evt_valid !== 1'b0 || bus.evt_count !== '0 || bus.evt_data !== 6'd0 || bus.ovf !== 1'b0 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL midhold_reset: valid %b count %0d data %h ovf %b irq %b expected all 0", bus.evt_valid, bus.evt_count, bus.evt_data, bus.ovf, bus.irq);
    end
    repeat (3) step();
    bus.key_held = 0;
    repeat (5) step();
    checks++; if (bus.evt_count !== '0 || bus.evt_valid !== 1'b0) begin errors++; $display("FAIL midhold_norelease: count %0d valid %b expected 0 0", bus.evt_count, bus.evt_valid); end
  endtask

  task automatic test_random();
    int hold_left = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!rst) begin
        checks++; if (bus.evt_valid !== (m_q.size() > 0) || bus.evt_count !== CW'(m_q.size())) begin errors++; $display("FAIL rnd_count@%0d: valid %b count %0d expected %0d", i, bus.evt_valid, bus.evt_count, m_q.size()); end
        checks++; if (bus.evt_data !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", i, bus.evt_data, m_data); end
        checks++; if (bus.ovf !== m_ovf || bus.irq !== m_irq) begin errors++; $display("FAIL rnd_flags@%0d: ovf %b irq %b expected %b %b", i, bus.ovf, bus.irq, m_ovf, m_irq); end
      end
      rst = ($urandom % 400 == 0);
      bus.key_it = 0;
      if (hold_left == 0) begin
        bus.key_held = 0;
        if ($urandom % 6 == 0) begin
          bus.key_it = 1; bus.key_held = 1;
          bus.key_val = 4'($urandom);
          hold_left = $urandom_range(2, 55);
        end
      end else begin
        hold_left--;
        if ($urandom % 20 == 0) bus.key_it = 1;
      end
      bus.evt_pop = ($urandom % 4 == 0);
      bus.ovf_clr = ($urandom % 10 == 0);
      if ($urandom % 20 == 0) bus.irq_en = ~bus.irq_en;
      step();
    end
    rst = 0;
  endtask

  initial begin
    bus.key_it = 0; bus.key_held = 0; bus.key_val = 0;
    bus.evt_pop = 0; bus.ovf_clr = 0; bus.irq_en = 0;
    @(negedge clk);
    test_reset();
    test_short_press();
    test_long_hold();
    test_overflow();
    test_full_push_pop();
    test_spurious();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
